d_cache_param: RTL

D_CACHE_PARAM -- requirements
Module: d_cache_param

---
 rtl/d_cache_param.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/d_cache_param.sv
// Set-associative data cache with one 32-bit word per line, round-robin replacement and
// a selectable write-back/write-allocate or write-through/no-write-allocate policy.
module d_cache_param #(
    parameter int INDEX_WIDTH = 10,
    parameter int WAYS        = 2,
    parameter int WRITE_BACK  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic        cache_data_req,
    output logic        cache_data_wr,
    output logic [1:0]  cache_data_size,
    output logic [31:0] cache_data_addr,
    output logic [31:0] cache_data_wdata,
    input  logic [31:0] cache_data_rdata,
    input  logic        cache_data_addr_ok,
    input  logic        cache_data_data_ok
);
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int TAGW = 30 - INDEX_WIDTH;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WB, RM, UC} state_t;

    state_t                 state_q;
    logic                   acc_q;
    logic [31:0]            req_addr_q;
    logic [31:0]            req_wdata_q;
    logic                   req_wr_q;
    logic [1:0]             req_size_q;
    logic [WW-1:0]          victim_q;
    logic [WW-1:0]          hitw_q;
    logic                   hitv_q;
    logic [SETS-1:0]        valid_q [WAYS];
    logic [SETS-1:0]        dirty_q [WAYS];
    logic [WW-1:0]          ptr_q   [SETS];
    logic [TAGW-1:0]        tag_q   [WAYS][SETS];
    logic [31:0]            data_q  [WAYS][SETS];

    logic [INDEX_WIDTH-1:0] cidx, ridx;
    logic [TAGW-1:0]        ctag, rtag;
    logic                   cacheable, hit_any, inv_any, fast_hit, mem_done;
    logic [WW-1:0]          hit_way, inv_way, victim_d, ptr_d;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] a);
        logic [3:0]  be;
        logic [31:0] res;
        case (sz)
            2'd0:    be = 4'b0001 << a;
            2'd1:    be = 4'b0011 << a;
            default: be = 4'b1111;
        endcase
        res = old;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

    assign cidx      = cpu_data_addr[INDEX_WIDTH+1:2];
    assign ctag      = cpu_data_addr[31:INDEX_WIDTH+2];
    assign ridx      = req_addr_q[INDEX_WIDTH+1:2];
    assign rtag      = req_addr_q[31:INDEX_WIDTH+2];
    assign cacheable = cpu_data_addr[31:29] != 3'b101;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[w][cidx] && tag_q[w][cidx] == ctag && !hit_any) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[w][cidx] && !inv_any) begin
                inv_any = 1'b1;
                inv_way = WW'(w);
            end
        end
        victim_d = inv_any ? inv_way : ptr_q[cidx];
        ptr_d    = (ptr_q[cidx] == WW'(WAYS - 1)) ? '0 : ptr_q[cidx] + WW'(1);
    end

    // Write-through writes never complete as hits; they go through UC so memory sees them first.
    assign fast_hit = (state_q == IDLE) && cpu_data_req && cacheable && hit_any &&
                      (WRITE_BACK != 0 || !cpu_data_wr);
    assign mem_done = (state_q != IDLE) && cache_data_data_ok && (acc_q || cache_data_addr_ok);

    always_comb begin
        cpu_data_addr_ok = fast_hit || (state_q == UC && mem_done);
        cpu_data_data_ok = fast_hit || (state_q == UC && mem_done);
        cpu_data_rdata   = (state_q == UC) ? cache_data_rdata : data_q[hit_way][cidx];
        cache_data_req   = (state_q != IDLE) && !acc_q;
        cache_data_wr    = (state_q == WB) || (state_q == UC && req_wr_q);
        cache_data_size  = (state_q == UC) ? req_size_q : 2'd2;
        cache_data_wdata = (state_q == WB) ? data_q[victim_q][ridx] : req_wdata_q;
        case (state_q)
            WB:      cache_data_addr = {tag_q[victim_q][ridx], ridx, 2'b00};
            RM:      cache_data_addr = {req_addr_q[31:2], 2'b00};
            default: cache_data_addr = req_addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wr_q    <= 1'b0;
            req_size_q  <= '0;
            victim_q    <= '0;
            hitw_q      <= '0;
            hitv_q      <= 1'b0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int unsigned s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fast_hit) begin
                        if (cpu_data_wr) dirty_q[hit_way][cidx] <= 1'b1;
                    end else if (cpu_data_req) begin
                        req_addr_q  <= cpu_data_addr;
                        req_wdata_q <= cpu_data_wdata;
                        req_wr_q    <= cpu_data_wr;
                        req_size_q  <= cpu_data_size;
                        acc_q       <= 1'b0;
                        hitv_q      <= cacheable && hit_any;
                        hitw_q      <= hit_way;
                        if (!cacheable || (WRITE_BACK == 0 && cpu_data_wr)) begin
                            state_q <= UC;
                        end else begin
                            victim_q    <= victim_d;
                            ptr_q[cidx] <= ptr_d;
                            state_q     <= (valid_q[victim_d][cidx] && dirty_q[victim_d][cidx]) ? WB : RM;
                        end
                    end
                end
                default: begin
                    if (cache_data_addr_ok && !acc_q) acc_q <= 1'b1;
                    if (mem_done) begin
                        acc_q <= 1'b0;
                        case (state_q)
                            WB: begin
                                dirty_q[victim_q][ridx] <= 1'b0;
                                state_q                 <= RM;
                            end
                            RM: begin
                                valid_q[victim_q][ridx] <= 1'b1;
                                dirty_q[victim_q][ridx] <= 1'b0;
                                state_q                 <= IDLE;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (fast_hit && cpu_data_wr)
            data_q[hit_way][cidx] <= merge(data_q[hit_way][cidx], cpu_data_wdata,
                                           cpu_data_size, cpu_data_addr[1:0]);
        if (state_q == RM && mem_done) begin
            tag_q[victim_q][ridx]  <= rtag;
            data_q[victim_q][ridx] <= cache_data_rdata;
        end
        if (state_q == UC && mem_done && hitv_q)
            data_q[hitw_q][ridx] <= merge(data_q[hitw_q][ridx], req_wdata_q,
                                          req_size_q, req_addr_q[1:0]);
    end
endmodule
